// File: rtl/nn_seq_pkg.sv
// Shared types and default sizing for the two-layer MLP control sequencer.
package nn_seq_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StL1Clr,
        StL1Mac,
        StL1Drain,
        StL1Act,
        StW2Wait,
        StL2Mac,
        StL2Drain,
        StDone
    } seq_state_t;

    localparam int unsigned DEF_N_IN    = 784;
    localparam int unsigned DEF_N_HID   = 200;
    localparam int unsigned DEF_N_OUT   = 10;
    localparam int unsigned DEF_MAC_LAT = 2;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int unsigned cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IN_AW = cw(DEF_N_IN);
    localparam int unsigned HID_W = cw(DEF_N_HID);
    localparam int unsigned OUT_W = cw(DEF_N_OUT);

endpackage

// File: rtl/nn_seq_drain_timer.sv
// Loadable down-counter; expired is high once the loaded count has run down to zero.
module nn_seq_drain_timer
    import nn_seq_pkg::*;
#(
    parameter int unsigned W = cw(DEF_MAC_LAT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/nn_layer_sequencer.sv
// FSM and index counters driving the 784-200-10 MLP datapath.
// Define NN_SEQ_PERF_CNT_EN to add the stall_cnt performance counter output.
module nn_layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter int unsigned N_IN    = DEF_N_IN,
    parameter int unsigned N_HID   = DEF_N_HID,
    parameter int unsigned N_OUT   = DEF_N_OUT,
    parameter int unsigned MAC_LAT = DEF_MAC_LAT,
    localparam int unsigned IAW    = cw(N_IN),
    localparam int unsigned HW     = cw(N_HID),
    localparam int unsigned OW     = cw(N_OUT)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           w1_valid,
    output logic           w1_ready,
    input  logic           w2_row_valid,
    output logic           w2_load_next_row,
    output logic [IAW-1:0] pix_addr,
    output logic [HW-1:0]  hid_idx,
    output logic [OW-1:0]  out_idx,
    output logic           acc1_clr,
    output logic           acc1_en,
    output logic           act_en,
    output logic           acc2_clr,
    output logic           acc2_en,
    output logic           busy,
    output logic           done
`ifdef NN_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]    stall_cnt
`endif
);

    localparam int unsigned TW = cw(MAC_LAT);

    seq_state_t     state_q, state_d;
    logic [IAW-1:0] j_q, j_d;
    logic [HW-1:0]  hid_q, hid_d;
    logic [OW-1:0]  k_q, k_d;
    logic           drain_load;
    logic           drain_expired;
    logic           w1_hs;

    assign w1_hs = (state_q == StL1Mac) && w1_valid;

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        hid_d      = hid_q;
        k_d        = k_q;
        drain_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StL1Clr;
                    hid_d   = '0;
                end
            end
            StL1Clr: begin
                j_d     = '0;
                state_d = StL1Mac;
            end
            StL1Mac: begin
                if (w1_hs) begin
                    if (j_q == IAW'(N_IN - 1)) begin
                        j_d        = '0;
                        drain_load = 1'b1;
                        state_d    = StL1Drain;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            StL1Drain: begin
                if (drain_expired) state_d = StL1Act;
            end
            StL1Act: state_d = StW2Wait;
            StW2Wait: begin
                if (w2_row_valid) begin
                    k_d     = '0;
                    state_d = StL2Mac;
                end
            end
            StL2Mac: begin
                if (k_q == OW'(N_OUT - 1)) begin
                    k_d = '0;
                    if (hid_q == HW'(N_HID - 1)) begin
                        drain_load = 1'b1;
                        state_d    = StL2Drain;
                    end else begin
                        hid_d   = hid_q + 1'b1;
                        state_d = StL1Clr;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StL2Drain: begin
                if (drain_expired) state_d = StDone;
            end
            StDone: begin
                hid_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            j_q     <= '0;
            hid_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            hid_q   <= hid_d;
            k_q     <= k_d;
        end
    end

    // Loaded on the edge entering a drain state so the state lasts exactly MAC_LAT cycles.
    nn_seq_drain_timer #(
        .W(TW)
    ) u_drain_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (drain_load),
        .load_val(TW'(MAC_LAT - 1)),
        .expired (drain_expired)
    );

    assign w1_ready         = (state_q == StL1Mac);
    assign acc1_en          = w1_hs;
    assign pix_addr         = (state_q == StL1Mac) ? j_q : '0;
    assign acc1_clr         = (state_q == StL1Clr);
    // Layer-2 accumulators are cleared once, alongside the first hidden neuron's clear.
    assign acc2_clr         = (state_q == StL1Clr) && (hid_q == '0);
    assign act_en           = (state_q == StL1Act);
    assign w2_load_next_row = (state_q == StW2Wait);
    assign acc2_en          = (state_q == StL2Mac);
    assign out_idx          = (state_q == StL2Mac) ? k_q : '0;
    assign hid_idx          = hid_q;
    assign busy             = (state_q != StIdle) && (state_q != StDone);
    assign done             = (state_q == StDone);

`ifdef NN_SEQ_PERF_CNT_EN
    logic        in_wait_q;
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_wait_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            in_wait_q <= (state_q == StW2Wait);
            if ((state_q == StIdle) && start) begin
                stall_q <= '0;
            end else if (((state_q == StL1Mac) && !w1_valid) ||
                         ((state_q == StW2Wait) && in_wait_q)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer in a small configuration (4 inputs, 2 hidden, 3 outputs).
module tb_nn_layer_sequencer;

    localparam int unsigned NI = 4;
    localparam int unsigned NH = 2;
    localparam int unsigned NO = 3;
    localparam int unsigned ML = 2;

    logic       clk = 1'b0;
    logic       reset, start, w1_valid, w2_row_valid;
    logic       w1_ready, w2_load_next_row;
    logic [1:0] pix_addr;
    logic [0:0] hid_idx;
    logic [1:0] out_idx;
    logic       acc1_clr, acc1_en, act_en, acc2_clr, acc2_en, busy, done;
`ifdef NN_SEQ_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    nn_layer_sequencer #(
        .N_IN   (NI),
        .N_HID  (NH),
        .N_OUT  (NO),
        .MAC_LAT(ML)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .w1_valid        (w1_valid),
        .w1_ready        (w1_ready),
        .w2_row_valid    (w2_row_valid),
        .w2_load_next_row(w2_load_next_row),
        .pix_addr        (pix_addr),
        .hid_idx         (hid_idx),
        .out_idx         (out_idx),
        .acc1_clr        (acc1_clr),
        .acc1_en         (acc1_en),
        .act_en          (act_en),
        .acc2_clr        (acc2_clr),
        .acc2_en         (acc2_en),
        .busy            (busy),
        .done            (done)
`ifdef NN_SEQ_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    typedef struct packed {
        logic       w1r;
        logic       w2l;
        logic       a1c;
        logic       a1e;
        logic       act;
        logic       a2c;
        logic       a2e;
        logic       bsy;
        logic       dn;
        logic [1:0] pix;
        logic       hid;
        logic [1:0] oi;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp;
    } vec_t;

    function automatic obs_t mk(input logic w1r, input logic w2l, input logic a1c,
                                input logic a1e, input logic act, input logic a2c,
                                input logic a2e, input logic bsy, input logic dn,
                                input logic [1:0] pix, input logic hid, input logic [1:0] oi);
        obs_t o;
        o.w1r = w1r; o.w2l = w2l; o.a1c = a1c; o.a1e = a1e; o.act = act; o.a2c = a2c;
        o.a2e = a2e; o.bsy = bsy; o.dn = dn; o.pix = pix; o.hid = hid; o.oi = oi;
        return o;
    endfunction

    obs_t now_obs;
    assign now_obs = mk(w1_ready, w2_load_next_row, acc1_clr, acc1_en, act_en, acc2_clr,
                        acc2_en, busy, done, pix_addr, hid_idx[0], out_idx);

    int   nvec = 0;
    int   nerr = 0;
    obs_t cap [0:63];
    int   n_a1e, n_act, n_a2e, n_w2l, n_done, done_cyc, first_a2e;
    int   outseq [0:15];
    int   stall_end;
    vec_t tab [15];

    task automatic check(input string name, input int act_v, input int exp_v);
        nvec++;
        if (act_v != exp_v) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act_v, exp_v);
        end
    endtask

    task automatic check_obs(input string name, input obs_t act_v, input obs_t exp_v);
        nvec++;
        if (act_v !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act_v, exp_v);
        end
    endtask

    // Cycle c is the interval after the (c-1)-th edge following the start-sample edge;
    // inputs are set #1 after the edge, outputs sampled on the falling edge.
    task automatic run(input int ncyc, input int w1_from, input int w1_len,
                       input int w2_from, input int w2_len, input int restart_at,
                       input int reset_at);
        n_a1e = 0; n_act = 0; n_a2e = 0; n_w2l = 0; n_done = 0;
        done_cyc = -1; first_a2e = -1; stall_end = 0;
        for (int c = 0; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start        = (c == 0) || (c == restart_at);
            reset        = (c == reset_at);
            w1_valid     = !(c >= w1_from && c < w1_from + w1_len);
            w2_row_valid = !(c >= w2_from && c < w2_from + w2_len);
            @(negedge clk);
            if (c >= 1 && c < 64) begin
                cap[c] = now_obs;
                if (acc1_en) n_a1e++;
                if (act_en) n_act++;
                if (w2_load_next_row) n_w2l++;
                if (acc2_en) begin
                    if (first_a2e < 0) first_a2e = c;
                    if (n_a2e < 16) outseq[n_a2e] = int'(out_idx);
                    n_a2e++;
                end
                if (done) begin
                    if (done_cyc < 0) done_cyc = c;
                    n_done++;
                end
`ifdef NN_SEQ_PERF_CNT_EN
                stall_end = int'(stall_cnt);
`endif
            end
        end
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0; w1_valid = 1'b1; w2_row_valid = 1'b1;
    endtask

    initial begin
        tab[0]  = '{1,  mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 2'd0, 0, 2'd0)};
        tab[1]  = '{2,  mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 2'd0, 0, 2'd0)};
        tab[2]  = '{4,  mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 2'd2, 0, 2'd0)};
        tab[3]  = '{5,  mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 2'd3, 0, 2'd0)};
        tab[4]  = '{6,  mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 2'd0)};
        tab[5]  = '{8,  mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 2'd0, 0, 2'd0)};
        tab[6]  = '{9,  mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 2'd0)};
        tab[7]  = '{10, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 0, 2'd0)};
        tab[8]  = '{12, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 0, 2'd2)};
        tab[9]  = '{13, mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 2'd0, 1, 2'd0)};
        tab[10] = '{17, mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 2'd3, 1, 2'd0)};
        tab[11] = '{23, mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 1, 2'd1)};
        tab[12] = '{26, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1, 2'd0)};
        tab[13] = '{27, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 1, 2'd0)};
        tab[14] = '{28, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0)};

        reset = 1'b1; start = 1'b0; w1_valid = 1'b1; w2_row_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_obs("reset outputs", now_obs, '0);
`ifdef NN_SEQ_PERF_CNT_EN
        check("reset stall_cnt", int'(stall_cnt), 0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        // Stall-free run checked against the per-cycle table.
        run(30, 1000, 0, 1000, 0, -1, -1);
        foreach (tab[i]) check_obs($sformatf("cycle %0d", tab[i].cyc), cap[tab[i].cyc], tab[i].exp);
        check("done cycle", done_cyc, 27);
        check("done pulses", n_done, 1);
        check("acc1_en cycles", n_a1e, 8);
        check("act_en pulses", n_act, 2);
        check("acc2_en cycles", n_a2e, 6);
        for (int i = 0; i < 6; i++) check($sformatf("out_idx seq %0d", i), outseq[i], i % 3);
`ifdef NN_SEQ_PERF_CNT_EN
        check("stall_cnt no stall", stall_end, 0);
`endif

        // start while busy is ignored.
        run(30, 1000, 0, 1000, 0, 10, -1);
        check("restart done cycle", done_cyc, 27);
        check("restart done pulses", n_done, 1);
        check("restart act_en pulses", n_act, 2);

        // weight1 stall at j==2 for five cycles.
        run(36, 4, 5, 1000, 0, -1, -1);
        for (int c = 4; c <= 8; c++)
            check_obs($sformatf("w1 stall cycle %0d", c), cap[c],
                      mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 2'd2, 0, 2'd0));
        check_obs("w1 stall release", cap[9], mk(1, 0, 0, 1, 0, 0, 0, 1, 0, 2'd2, 0, 2'd0));
        check("w1 stall pix after", int'(cap[10].pix), 3);
        check("w1 stall done cycle", done_cyc, 32);
        check("w1 stall acc1_en cycles", n_a1e, 8);
`ifdef NN_SEQ_PERF_CNT_EN
        check("w1 stall stall_cnt", stall_end, 5);
`endif

        // weight2 row not ready for seven cycles after the first W2_WAIT entry.
        run(38, 1000, 0, 9, 7, -1, -1);
        check("w2 wait load cycles", n_w2l, 9);
        check("w2 wait load last", int'(cap[16].w2l), 1);
        check("w2 wait first acc2_en", first_a2e, 17);
        check("w2 wait done cycle", done_cyc, 34);
`ifdef NN_SEQ_PERF_CNT_EN
        check("w2 wait stall_cnt", stall_end, 7);
`endif

        // Reset mid-operation.
        run(40, 1000, 0, 1000, 0, -1, 15);
        check_obs("mid reset outputs", cap[16], '0);
        check("mid reset no done", n_done, 0);

        // Clean sequence after the abort.
        run(30, 1000, 0, 1000, 0, -1, -1);
        check("post reset done cycle", done_cyc, 27);
        check_obs("post reset cycle 13", cap[13], tab[9].exp);

        // start coincident with reset.
        run(6, 1000, 0, 1000, 0, -1, 0);
        check_obs("start with reset", cap[1], '0);
        check("start with reset no done", n_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/nn_layer_sequencer.md
Name: nn_layer_sequencer

Overview:
- Control sequencer for the two-layer MLP datapath (784→200→10, 10 images processed in parallel lanes).
- Generates the pixel-SRAM read address, hidden/output indices and accumulate/activate strobes.
- Applies flow control to the off-chip weight1 stream and to the weight2 row loads.
- Sits between the off-chip loader and the Top MAC/activation datapath; replaces bench-driven free-running sequencing.

Parameters:
- N_IN, 784, inputs per image (pixel-SRAM depth)
- N_HID, 200, hidden neurons
- N_OUT, 10, output classes (weight2 entries per row)
- MAC_LAT, 2, MAC pipeline depth in cycles (drain time before a result is valid)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin inference; sampled only in IDLE
- w1_valid  in  1  weight1 word present on datapath input
- w1_ready  out  1  sequencer consumes weight1 word this cycle
- w2_row_valid  in  1  weight2 SRAM holds the row for the current hidden index
- w2_load_next_row  out  1  request next weight2 row (level)
- pix_addr  out  $clog2(N_IN)  pixel-SRAM read address
- hid_idx  out  $clog2(N_HID)  current hidden neuron
- out_idx  out  $clog2(N_OUT)  weight2/output-accumulator select
- acc1_clr  out  1  clear layer-1 accumulators
- acc1_en  out  1  layer-1 MAC enable
- act_en  out  1  apply activation and latch the hidden value
- acc2_clr  out  1  clear layer-2 accumulators
- acc2_en  out  1  layer-2 MAC enable
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse; final outputs valid

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- States: IDLE, L1_CLR, L1_MAC, L1_DRAIN, L1_ACT, W2_WAIT, L2_MAC, L2_DRAIN, DONE.
- IDLE:
  - start=1 → L1_CLR.
  - On the transition, assert acc2_clr for one cycle and set busy=1.
  - hid_idx=0.
- L1_CLR: acc1_clr=1 for one cycle; j=0; → L1_MAC.
- L1_MAC:
  - w1_ready=1, pix_addr=j.
  - acc1_en = w1_valid & w1_ready.
  - j increments only on handshake; w1_valid=0 stalls (hold j, acc1_en=0).
  - On the handshake with j==N_IN-1 → L1_DRAIN.
- L1_DRAIN: MAC_LAT cycles, all strobes 0; → L1_ACT.
- L1_ACT: act_en=1 for exactly one cycle; → W2_WAIT.
- W2_WAIT:
  - w2_load_next_row=1 while in this state.
  - Leave on the first cycle w2_row_valid=1 → L2_MAC with k=0.
  - If w2_row_valid is already 1 on entry, the state lasts exactly 1 cycle.
- L2_MAC:
  - acc2_en=1, out_idx=k; k increments each cycle (no stall).
  - At k==N_OUT-1: if hid_idx==N_HID-1 → L2_DRAIN; else hid_idx++ → L1_CLR.
- L2_DRAIN: MAC_LAT cycles; → DONE.
- DONE: done=1 for one cycle, busy→0; → IDLE.
- out_idx=0 and pix_addr=0 outside L2_MAC and L1_MAC respectively.
- Zero-stall latency:
  - Per hidden neuron: 1+N_IN+MAC_LAT+1+1+N_OUT cycles (799 at defaults).
  - done asserts N_HID×that+MAC_LAT+1 cycles after the start-sample edge (159,803 at defaults).
- start while busy: ignored. start coincident with reset: reset wins.
- reset mid-operation: next cycle IDLE, all strobes 0, no done pulse.
- w1_valid high outside L1_MAC: ignored (w1_ready=0).
- Counters wrap never; terminal compares are exact.

Optional Feature:
- NN_SEQ_PERF_CNT_EN defined:
  - Adds output stall_cnt [31:0], counting cycles in L1_MAC with w1_valid=0 plus cycles in W2_WAIT beyond the first.
  - Cleared on start acceptance and on reset; holds after done.
- Undefined: port absent, no counter logic.

Decomposition:
- Package nn_seq_pkg holds:
  - state enum seq_state_t;
  - default sizes N_IN/N_HID/N_OUT/MAC_LAT;
  - width localparams IN_AW, HID_W, OUT_W.
- Sub-module nn_seq_drain_timer: loadable down-counter, reused by L1_DRAIN and L2_DRAIN.
- FSM and index counters stay in the top module.

Test Plan:
- Small config, stall-free (N_IN=4, N_HID=2, N_OUT=3, MAC_LAT=2, w1_valid=1 and w2_row_valid=1 constant), start pulse → done exactly 27 cycles after the start edge; acc1_en asserted for 8 cycles, act_en 2 pulses, acc2_en 6 cycles with out_idx sequence 0,1,2,0,1,2.
- Same config, w1_valid low at j=2 for 5 cycles → pix_addr holds 2, acc1_en=0 for those cycles, done delayed by exactly 5 cycles (stall_cnt=5 with NN_SEQ_PERF_CNT_EN).
- w2_row_valid held low for 7 cycles after W2_WAIT entry → w2_load_next_row high 8 cycles, acc2_en starts the cycle after w2_row_valid rises.
- start re-pulsed at cycle 10 while busy → no restart, done timing unchanged; reset at cycle 15 → all outputs 0 next cycle, busy=0, no done pulse; new start runs a clean full sequence.
- Default parameters, stall-free → done at cycle 159,803, hid_idx reaches 199, act_en count 200.
